// File: rtl/decode_pkg.sv
// Decoded-instruction layout shared by the decode mux, decode_queue and issue.
// Fields are packed MSB-first in the order listed below; ENTRY_W is their sum.
package decode_pkg;

    localparam int OPCODE_W = 12;
    localparam int ADDR_W   = 64;
    localparam int FU_W     = 3;
    localparam int MAJID_W  = 64;
    localparam int MINID_W  = 7;
    localparam int IS64_W   = 1;
    localparam int PID_W    = 20;
    localparam int TID_W    = 16;
    localparam int RW_W     = 4 * 2;
    localparam int ISREG_W  = 4;
    localparam int BODY_W   = 84;

    localparam int ENTRY_W = OPCODE_W + ADDR_W + FU_W + MAJID_W + MINID_W + IS64_W
                           + PID_W + TID_W + RW_W + ISREG_W + BODY_W;

    localparam int BODY_LSB   = 0;
    localparam int ISREG_LSB  = BODY_LSB  + BODY_W;
    localparam int RW_LSB     = ISREG_LSB + ISREG_W;
    localparam int TID_LSB    = RW_LSB    + RW_W;
    localparam int PID_LSB    = TID_LSB   + TID_W;
    localparam int IS64_LSB   = PID_LSB   + PID_W;
    localparam int MINID_LSB  = IS64_LSB  + IS64_W;
    localparam int MAJID_LSB  = MINID_LSB + MINID_W;
    localparam int FU_LSB     = MAJID_LSB + MAJID_W;
    localparam int ADDR_LSB   = FU_LSB    + FU_W;
    localparam int OPCODE_LSB = ADDR_LSB  + ADDR_W;

    typedef enum logic [FU_W-1:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_DIV  = 3'd2,
        FU_LSU  = 3'd3,
        FU_BRU  = 3'd4,
        FU_FPU  = 3'd5,
        FU_CSR  = 3'd6,
        FU_NONE = 3'd7
    } func_unit_e;

    typedef enum logic [3:0] {
        FMT_R   = 4'd0,
        FMT_I   = 4'd1,
        FMT_S   = 4'd2,
        FMT_B   = 4'd3,
        FMT_U   = 4'd4,
        FMT_J   = 4'd5,
        FMT_SYS = 4'd6
    } format_id_e;

endpackage

// File: rtl/decode_queue_ram.sv
// 1W/1R storage for decode_queue: synchronous write, asynchronous read.
// Kept separate so it can be replaced by an FPGA LUTRAM primitive.
module decode_queue_ram #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int ENTRY_W = 283
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between the decode mux and issue, with early stall.
// Optional statistics counters are enabled by defining DECODE_QUEUE_STATS_EN.
module decode_queue #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int ENTRY_W     = decode_pkg::ENTRY_W,
    parameter int AFULL_SLACK = 3
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] entry_i,
    output logic               almost_full_o,
    output logic               full_o,
    output logic               overflow_o,
    output logic [PTR_W:0]     count_o,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] entry_o,
    input  logic               ready_i
`ifdef DECODE_QUEUE_STATS_EN
   ,output logic [31:0]        stat_push_o,
    output logic [31:0]        stat_pop_o,
    output logic [15:0]        stat_drop_o,
    output logic [PTR_W:0]     stat_maxocc_o
`endif
);
    import decode_pkg::*;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] SLACK_C = (PTR_W+1)'(AFULL_SLACK);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [PTR_W:0] r_count;
    logic           r_overflow;

    logic           w_valid;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_we;
    logic [PTR_W:0] w_free;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = w_valid && ready_i;
    // A pop in the same cycle frees the head slot, so a full queue still accepts.
    assign w_push  = push_i && (!w_full || w_pop);
    assign w_we    = w_push && !flush_i;
    assign w_free  = DEPTH_C - r_count;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (push_i && !w_push) r_overflow <= 1'b1;
        end
    end

    decode_queue_ram #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .i_clk   (clock_i),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (entry_i),
        .i_raddr (r_rd_ptr[PTR_W-1:0]),
        .o_rdata (entry_o)
    );

    assign valid_o       = w_valid;
    assign full_o        = w_full;
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;
    assign almost_full_o = (w_free <= SLACK_C);

`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0]    r_stat_push;
    logic [31:0]    r_stat_pop;
    logic [15:0]    r_stat_drop;
    logic [PTR_W:0] r_stat_maxocc;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // Counters survive flush so they reflect total traffic since reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stat_push   <= '0;
            r_stat_pop    <= '0;
            r_stat_drop   <= '0;
            r_stat_maxocc <= '0;
        end else begin
            if (w_we)                          r_stat_push <= sat_inc32(r_stat_push);
            if (w_pop && !flush_i)             r_stat_pop  <= sat_inc32(r_stat_pop);
            if (push_i && !w_push && !flush_i) r_stat_drop <= sat_inc16(r_stat_drop);
            if (r_count > r_stat_maxocc)       r_stat_maxocc <= r_count;
        end
    end

    assign stat_push_o   = r_stat_push;
    assign stat_pop_o    = r_stat_pop;
    assign stat_drop_o   = r_stat_drop;
    assign stat_maxocc_o = r_stat_maxocc;

`ifndef SYNTHESIS
    always @(posedge clock_i) begin
        if (reset_n_i && !flush_i && w_push) $display("decode_queue push %h", entry_i);
        if (reset_n_i && !flush_i && w_pop)  $display("decode_queue pop  %h", entry_o);
    end
`endif
`endif

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Decoded-instruction FIFO between the decode mux (third decode stage) and issue/dispatch.
- Captures one packed decoded instruction per cycle when the mux asserts its enable; that stage has no stall input.
- Presents instructions in order to issue with a valid/ready handshake.
- Gives decode an early almost-full stall so in-flight decode stages can drain without overflow.

Parameters:
- DEPTH, 16, entries; power of two, >= 4.
- PTR_W, 4, log2(DEPTH).
- ENTRY_W, 283, packed decoded-instruction width (layout in package).
- AFULL_SLACK, 3, almost_full asserts when free entries <= AFULL_SLACK (covers decode stages in flight).

Ports:
- clock_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries (branch redirect/exception).
- push_i  in  1  decode mux enable; entry_i valid this cycle.
- entry_i  in  ENTRY_W  packed decoded instruction.
- almost_full_o  out  1  stall request to fetch/decode.
- full_o  out  1  no free entry.
- overflow_o  out  1  sticky; push arrived while no slot was available.
- count_o  out  PTR_W+1  occupancy, 0..DEPTH.
- valid_o  out  1  head entry present.
- entry_o  out  ENTRY_W  head entry; stable while valid_o && !ready_i.
- ready_i  in  1  issue accepts the head this cycle.

Behaviour:
- Storage: DEPTH x ENTRY_W array. Write/read pointers are PTR_W+1 bits; the MSB is the wrap bit.
  - empty = ptrs equal.
  - full = low bits equal and MSBs differ.
- Reset (async, reset_n_i low):
  - Pointers, count_o, overflow_o, valid_o and full_o go to 0; almost_full_o goes to 0 (AFULL_SLACK < DEPTH).
  - Array contents are not reset; entry_o is don't-care while valid_o = 0.
  - Reset mid-operation discards all entries.
- pop = valid_o && ready_i.
- push accepted = push_i && (!full_o || pop). When full, a simultaneous pop frees the head slot, so push and pop both proceed and count is unchanged.
- push_i while full_o && !pop:
  - Entry dropped; pointers unchanged.
  - overflow_o set, cleared only by reset.
  - Never corrupts stored data.
- Occupancy per cycle:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - count_o is registered and equals wr_ptr - rd_ptr (PTR_W+1 bit modular).
- Latency: push at edge N into an empty queue gives valid_o = 1 and entry_o = that entry in the cycle after edge N. There is no same-cycle bypass.
- valid_o = (count != 0). entry_o = array[rd_ptr low bits], read combinationally from registered pointers.
- almost_full_o = (DEPTH - count_o) <= AFULL_SLACK. full_o = (count_o == DEPTH). Both are derived from registered state.
- flush_i (synchronous):
  - Priority over push and pop in the same cycle.
  - rd_ptr := wr_ptr; count := 0; push and pop that cycle are ignored.
  - overflow_o is unaffected.
- Wrap-around: pointers increment modulo 2*DEPTH; ordering is preserved across wrap.
- ready_i while !valid_o has no effect.

Optional Feature:
- Macro: DECODE_QUEUE_STATS_EN.
- With it defined, extra outputs are added:
  - stat_push_o, 32 b: accepted pushes.
  - stat_pop_o, 32 b: pops.
  - stat_drop_o, 16 b: dropped pushes.
  - stat_maxocc_o, PTR_W+1 b: high-water occupancy.
  - All reset to 0 asynchronously, saturate at max, and are unaffected by flush_i.
  - A $display of each push/pop is emitted under simulation only.
- Without it: these ports and all counter logic are absent; core behaviour is identical.

Decomposition:
- Package decode_pkg holds:
  - Field widths: opcode 12, address 64, funcUnit 3, majId 64, minId 7, is64Bit 1, pid 20, tid 16, rw 4x2, isReg 4, body 84.
  - Their bit offsets within the packed entry, in that order from MSB.
  - ENTRY_W derived from their sum.
  - Func-unit and format id constants.
- One sub-module is natural: decode_queue_ram (1W/1R, DEPTH x ENTRY_W, synchronous write, async read), so it can be swapped for an FPGA LUTRAM.

Test Plan:
- Reset: hold reset_n_i low, then release → valid_o=0, count_o=0, full_o=0, almost_full_o=0, overflow_o=0.
- Order and latency: push 3 entries (opcode 1,2,3) with ready_i=0, then set ready_i=1 → valid_o rises 1 cycle after the first push; entries pop as 1,2,3; count_o goes 3,2,1,0.
- Full plus simultaneous push/pop: fill 16 entries → full_o=1, almost_full_o=1 from count 13. Then push and pop in the same cycle → count_o stays 16, the new entry is last out, overflow_o=0.
- Overflow: at full, push with ready_i=0 → overflow_o=1, count_o=16, and drain returns the original 16 unchanged.
- Flush: 5 entries present; flush_i together with push_i and ready_i → next cycle count_o=0, valid_o=0. A push afterwards appears 1 cycle later.
- Wrap: 40 continuous push/pop cycles with random ready_i → output sequence equals input sequence and count_o always matches the model.
